// File: rtl/ds18b20_ctrl.sv
// 1-Wire master running a complete DS18B20 read on a single start pulse:
// reset/presence, CC 44, conversion wait, reset/presence, CC BE, 9-byte read, CRC8 check.
module ds18b20_ctrl #(
  parameter int CLK_FREQ_HZ  = 50_000_000,
  parameter int CONV_WAIT_US = 750_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] temp_data,
  output logic        temp_valid,
  output logic        presence_err,
  output logic        crc_err,
  output logic        dq_oe,
  input  logic        dq_in
);

  localparam int TICK_DIV = (CLK_FREQ_HZ / 1_000_000 > 0) ? CLK_FREQ_HZ / 1_000_000 : 1;
  localparam int PRESC_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  // Timer compare values are "last count" values: a phase of N us ends on its Nth tick.
  localparam logic [31:0] RST_LOW_LAST   = 32'd479;
  localparam logic [31:0] PRES_LAST      = 32'd69;
  localparam logic [31:0] RST_TOTAL_LAST = 32'd479;
  localparam logic [31:0] SLOT_LAST      = 32'd69;
  localparam logic [31:0] WR1_LOW_LAST   = 32'd5;
  localparam logic [31:0] WR0_LOW_LAST   = 32'd59;
  localparam logic [31:0] RD_LOW_LAST    = 32'd5;
  localparam logic [31:0] RD_SAMPLE_LAST = 32'd13;
  localparam logic [31:0] CONV_LAST      = 32'(CONV_WAIT_US - 1);

  localparam logic [7:0] CMD_SKIP_ROM = 8'hCC;
  localparam logic [7:0] CMD_CONVERT  = 8'h44;
  localparam logic [7:0] CMD_READ_SP  = 8'hBE;

  typedef enum logic [3:0] {
    IDLE, RST_LOW, RST_SAMPLE, RST_RECOVER, WR_SLOT, RD_SLOT, CONV_WAIT, CHECK, FINISH
  } state_t;

  state_t             state_reg;
  logic [PRESC_W-1:0] presc_reg;
  logic               tick;
  logic [1:0]         dq_sync_reg;
  logic               dq_s;
  logic [31:0]        us_cnt_reg;
  logic               phase_reg;
  logic               cmd_idx_reg;
  logic [7:0]         tx_byte_reg;
  logic [2:0]         bit_cnt_reg;
  logic [6:0]         rd_cnt_reg;
  logic [7:0]         rx_byte_reg;
  logic [7:0]         crc_reg;
  logic [15:0]        hold_reg;

  logic [7:0]         rx_next;
  logic [7:0]         crc_next;
  logic [31:0]        wr_low_last;

  assign tick = (presc_reg == PRESC_W'(TICK_DIV - 1));
  assign dq_s = dq_sync_reg[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg <= '0;
    end else if (tick) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end

  // Idle bus level is high, so the synchronizer resets to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq_sync_reg <= 2'b11;
    end else begin
      dq_sync_reg <= {dq_sync_reg[0], dq_in};
    end
  end

  always_comb begin
    rx_next     = {dq_s, rx_byte_reg[7:1]};
    crc_next    = {1'b0, crc_reg[7:1]} ^ ((crc_reg[0] ^ dq_s) ? 8'h8C : 8'h00);
    wr_low_last = tx_byte_reg[0] ? WR1_LOW_LAST : WR0_LOW_LAST;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      us_cnt_reg   <= '0;
      phase_reg    <= 1'b0;
      cmd_idx_reg  <= 1'b0;
      tx_byte_reg  <= '0;
      bit_cnt_reg  <= '0;
      rd_cnt_reg   <= '0;
      rx_byte_reg  <= '0;
      crc_reg      <= '0;
      hold_reg     <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      temp_data    <= '0;
      temp_valid   <= 1'b0;
      presence_err <= 1'b0;
      crc_err      <= 1'b0;
      dq_oe        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            busy         <= 1'b1;
            temp_valid   <= 1'b0;
            presence_err <= 1'b0;
            crc_err      <= 1'b0;
            phase_reg    <= 1'b0;
            us_cnt_reg   <= '0;
            dq_oe        <= 1'b1;
            state_reg    <= RST_LOW;
          end
        end

        RST_LOW: begin
          if (tick) begin
            if (us_cnt_reg == RST_LOW_LAST) begin
              us_cnt_reg <= '0;
              dq_oe      <= 1'b0;
              state_reg  <= RST_SAMPLE;
            end else begin
              us_cnt_reg <= us_cnt_reg + 32'd1;
            end
          end
        end

        // us_cnt keeps running across SAMPLE and RECOVER, both measured from release.
        RST_SAMPLE: begin
          if (tick) begin
            us_cnt_reg <= us_cnt_reg + 32'd1;
            if (us_cnt_reg == PRES_LAST) begin
              if (dq_s) begin
                presence_err <= 1'b1;
                state_reg    <= FINISH;
              end else begin
                state_reg <= RST_RECOVER;
              end
            end
          end
        end

        RST_RECOVER: begin
          if (tick) begin
            if (us_cnt_reg == RST_TOTAL_LAST) begin
              us_cnt_reg  <= '0;
              cmd_idx_reg <= 1'b0;
              tx_byte_reg <= CMD_SKIP_ROM;
              bit_cnt_reg <= '0;
              dq_oe       <= 1'b1;
              state_reg   <= WR_SLOT;
            end else begin
              us_cnt_reg <= us_cnt_reg + 32'd1;
            end
          end
        end

        WR_SLOT: begin
          if (tick) begin
            if (us_cnt_reg == SLOT_LAST) begin
              us_cnt_reg <= '0;
              if (bit_cnt_reg != 3'd7) begin
                bit_cnt_reg <= bit_cnt_reg + 3'd1;
                tx_byte_reg <= {1'b0, tx_byte_reg[7:1]};
                dq_oe       <= 1'b1;
              end else if (!cmd_idx_reg) begin
                cmd_idx_reg <= 1'b1;
                bit_cnt_reg <= '0;
                tx_byte_reg <= phase_reg ? CMD_READ_SP : CMD_CONVERT;
                dq_oe       <= 1'b1;
              end else if (!phase_reg) begin
                state_reg <= CONV_WAIT;
              end else begin
                rd_cnt_reg <= '0;
                crc_reg    <= '0;
                dq_oe      <= 1'b1;
                state_reg  <= RD_SLOT;
              end
            end else begin
              us_cnt_reg <= us_cnt_reg + 32'd1;
              if (us_cnt_reg == wr_low_last) begin
                dq_oe <= 1'b0;
              end
            end
          end
        end

        RD_SLOT: begin
          if (tick) begin
            if (us_cnt_reg == SLOT_LAST) begin
              us_cnt_reg <= '0;
              if (rd_cnt_reg == 7'd71) begin
                state_reg <= CHECK;
              end else begin
                rd_cnt_reg <= rd_cnt_reg + 7'd1;
                dq_oe      <= 1'b1;
              end
            end else begin
              us_cnt_reg <= us_cnt_reg + 32'd1;
              if (us_cnt_reg == RD_LOW_LAST) begin
                dq_oe <= 1'b0;
              end
              if (us_cnt_reg == RD_SAMPLE_LAST) begin
                rx_byte_reg <= rx_next;
                crc_reg     <= crc_next;
                if (rd_cnt_reg == 7'd7) begin
                  hold_reg[7:0] <= rx_next;
                end
                if (rd_cnt_reg == 7'd15) begin
                  hold_reg[15:8] <= rx_next;
                end
              end
            end
          end
        end

        CONV_WAIT: begin
          if (tick) begin
            if (us_cnt_reg == CONV_LAST) begin
              us_cnt_reg <= '0;
              phase_reg  <= 1'b1;
              dq_oe      <= 1'b1;
              state_reg  <= RST_LOW;
            end else begin
              us_cnt_reg <= us_cnt_reg + 32'd1;
            end
          end
        end

        // Running the CRC over all nine bytes, including the CRC byte, leaves zero.
        CHECK: begin
          if (crc_reg == 8'h00) begin
            temp_data  <= hold_reg;
            temp_valid <= 1'b1;
          end else begin
            crc_err <= 1'b1;
          end
          state_reg <= FINISH;
        end

        FINISH: begin
          done      <= 1'b1;
          busy      <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          dq_oe     <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
